pm_reduce_pipe: RTL and testbench
=================================

Name: pm_reduce_pipe

Overview:
Parametrised, pipelined pseudo-Mersenne modular reducer for P = 2^N - C. It is the next generation of the single-cycle mod-q folder used behind the 255-bit multiplier. It adds a valid/ready stream interface, three pipeline stages with backpressure, a sideband tag, and per-transaction mode select: reduce a product, modular add, or modular subtract. It sits between the wide multiplier / adder datapath and the point-arithmetic controller.

Parameters:
N, 255, modulus bit width; P = 2^N - C
C, 19, pseudo-Mersenne offset; constraint: C < 2^CW and C*2^(CW+2) < P
CW, 5, bit width of C
TAG_W, 4, width of the sideband tag carried with each transaction

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept an input this cycle
in_mode  in  2  00 = MUL reduce, 01 = ADD, 10 = SUB, 11 = illegal
in_data  in  2N  MUL: full product X; ADD/SUB: a = in_data[N-1:0], b = in_data[2N-1:N]
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  N  reduced result, always in [0, P-1]
out_tag  out  TAG_W  tag of this result
out_err  out  1  transaction had illegal mode
busy  out  1  any stage holds a valid transaction

Behaviour:
- Reset (rst=0, async): all stage valid bits = 0, out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, busy = 0. Data registers in S1/S2 need no reset. Reset mid-operation discards all in-flight transactions; nothing is emitted after release.
- Pre-stage operand formation (combinational, on in_data):
  - MUL: X = in_data.
  - ADD: X = a + b, zero-extended to 2N bits.
  - SUB: X = a + (P - b), zero-extended.
  - a and b must be < P in ADD/SUB; behaviour for out-of-range a or b is undefined.
  - Illegal mode: X = 0 and err flag set.
- S1 register, fold 1: T2 = X[2N-1:N]*C + X[N-1:0], width N+CW+1.
- S2 register, fold 2: T3 = T2[N+CW:N]*C + T2[N-1:0], width N+1.
- S3 (output register), final correction:
  - Compute D = T3 - P as N+2-bit signed.
  - out_data = T3[N-1:0] if D is negative, else D[N-1:0].
  - Illegal mode forces out_data = 0 and out_err = 1.
- Multiplies by C are implemented as shift-add of C's set bits; no generic multiplier.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall = 0, every stage advances one position and S1 captures the input (valid = in_valid).
  - When stall = 1, all stages hold.
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - out_* stay stable while stalled.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput 1 per cycle.
- Bubbles propagate as invalid slots; they are not compacted.
- Ordering: strict FIFO. out_tag and out_err travel with their data.
- in_valid is allowed to drop without transfer; no input-side stickiness is required.
- Simultaneous output consume and input accept in the same cycle is legal at full throughput.
- busy = OR of the S1/S2/S3 valid bits.

Test Plan:
- Default params, MUL mode, three back-to-back inputs, out_ready = 1, tags 1/2/3: X = P -> 0; X = 2^255 -> 19; X = 2^510 - 1 -> 360. out_valid exactly 3 cycles after each accept, tags in order.
- ADD mode, a = P-1, b = 1 -> 0; a = P-1, b = P-1 -> P-2; a = 5, b = 7 -> 12.
- SUB mode, a = 0, b = 1 -> P-1; a = 7, b = 5 -> 2; a = b = 123 -> 0.
- Backpressure: stream 6 MUL transactions while out_ready is held low from cycle 4 to 9. Required: in_ready low whenever out_valid is high and out_ready is low, no loss or duplication, all 6 results and tags emerge in order, out_data stable while stalled.
- Illegal mode 11 with tag 0xA inside a stream -> out_err = 1, out_data = 0, out_tag = 0xA. Neighbouring transactions are unaffected.
- Reset mid-stream: assert rst low with 3 transactions in flight. Required: out_valid = 0 and busy = 0 immediately (async). After release, no stale results appear, and the first new input's result arrives 3 cycles after it is accepted.

Source files
------------

// File: rtl/pm_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pm_reduce_pipe
// Purpose  : Three-stage pipelined reducer mod P = 2^N - C with add/sub modes,
//            a valid/ready stream interface and a sideband tag.
// Revision : 1.0  initial release
// ============================================================================
module pm_reduce_pipe #(
  parameter int N     = 255,
  parameter int C     = 19,
  parameter int CW    = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [2*N-1:0]   in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam logic [N-1:0]  c_p        = {N{1'b1}} - N'(C - 1);
  localparam logic [CW-1:0] c_c        = CW'(C);
  localparam logic [1:0]    c_mode_mul = 2'b00;
  localparam logic [1:0]    c_mode_add = 2'b01;
  localparam logic [1:0]    c_mode_sub = 2'b10;

  // hi*C + lo, with the multiply expanded into shifted adds of C's set bits
  function automatic logic [N+CW:0] fold1(input logic [2*N-1:0] x);
    logic [N+CW:0] acc;
    acc = (N+CW+1)'(x[N-1:0]);
    for (int i = 0; i < CW; i++) begin
      if (c_c[i]) acc = acc + ((N+CW+1)'(x[2*N-1:N]) << i);
    end
    return acc;
  endfunction

  function automatic logic [N:0] fold2(input logic [N+CW:0] t2);
    logic [N:0] acc;
    acc = {1'b0, t2[N-1:0]};
    for (int i = 0; i < CW; i++) begin
      if (c_c[i]) acc = acc + ((N+1)'(t2[N+CW:N]) << i);
    end
    return acc;
  endfunction

  logic [N-1:0]     w_a;
  logic [N-1:0]     w_b;
  logic [2*N-1:0]   w_x;
  logic             w_err;
  logic             w_stall;
  logic             w_ge_p;
  logic [N-1:0]     w_result;

  logic             r_s1_valid;
  logic [N+CW:0]    r_s1_t2;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_err;
  logic             r_s2_valid;
  logic [N:0]       r_s2_t3;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_err;

  assign w_a = in_data[N-1:0];
  assign w_b = in_data[2*N-1:N];

  always_comb begin
    w_x   = '0;
    w_err = 1'b0;
    case (in_mode)
      c_mode_mul: w_x = in_data;
      c_mode_add: w_x = (2*N)'({1'b0, w_a} + {1'b0, w_b});
      c_mode_sub: w_x = (2*N)'({1'b0, w_a} + {1'b0, c_p - w_b});
      default:    w_err = 1'b1;
    endcase
  end

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign busy     = r_s1_valid | r_s2_valid | out_valid;

  // T3 < 2P after two folds, so one conditional subtract lands in [0, P-1]
  assign w_ge_p   = (r_s2_t3 >= {1'b0, c_p});
  assign w_result = w_ge_p ? (r_s2_t3[N-1:0] - c_p) : r_s2_t3[N-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      out_valid  <= r_s2_valid;
      if (r_s2_valid) begin
        out_data <= r_s2_err ? '0 : w_result;
        out_tag  <= r_s2_tag;
        out_err  <= r_s2_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s1_t2  <= fold1(w_x);
      r_s1_tag <= in_tag;
      r_s1_err <= w_err;
      r_s2_t3  <= fold2(r_s1_t2);
      r_s2_tag <= r_s1_tag;
      r_s2_err <= r_s1_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pm_reduce_pipe.sv
`default_nettype none
// Testbench for pm_reduce_pipe: directed and random streams against a
// big-integer modulo reference model, with backpressure and reset scenarios.
module tb_pm_reduce_pipe;

  localparam int N     = 255;
  localparam int C     = 19;
  localparam int CW    = 5;
  localparam int TAG_W = 4;
  localparam logic [N-1:0] P_C = {N{1'b1}} - N'(C - 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [2*N-1:0]   in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  pm_reduce_pipe #(.N(N), .C(C), .CW(CW), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  typedef struct {
    logic [2*N-1:0]   data;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     want;
    logic             werr;
    int               cyc;
  } txn_t;

  typedef struct {
    logic [N-1:0]     data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } obs_t;

  txn_t stim_q[$];
  txn_t exp_q[$];
  obs_t obs_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_bad = 0;
  int stable_bad = 0;
  int stall_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: records transfers and handshake/stability anomalies.
  initial begin
    logic             prev_stall;
    logic [N-1:0]     prev_data;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;
    obs_t             o;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (in_ready !== ~(out_valid & ~out_ready)) ready_bad++;
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data ||
                           out_tag !== prev_tag || out_err !== prev_err))
          stable_bad++;
        prev_stall = out_valid & ~out_ready;
        if (prev_stall) stall_cnt++;
        prev_data = out_data;
        prev_tag  = out_tag;
        prev_err  = out_err;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          o.data = out_data;
          o.tag  = out_tag;
          o.err  = out_err;
          o.cyc  = cyc;
          obs_q.push_back(o);
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Reference: plain big-integer remainder of the operand formed per mode.
  function automatic logic [N-1:0] ref_mod(input logic [2*N-1:0] d, input logic [1:0] mode);
    logic [511:0] p, a, b, x, r;
    p = 512'(P_C);
    a = 512'(d[N-1:0]);
    b = 512'(d[2*N-1:N]);
    case (mode)
      2'd0:    x = 512'(d);
      2'd1:    x = a + b;
      2'd2:    x = a + p - b;
      default: x = '0;
    endcase
    r = x % p;
    return r[N-1:0];
  endfunction

  function automatic logic [2*N-1:0] rand_wide();
    logic [511:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t = (t << 32) | 512'($urandom);
    return t[2*N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_fe();
    logic [2*N-1:0] w;
    logic [N-1:0]   v;
    int             s;
    s = $urandom_range(0, 7);
    w = rand_wide();
    v = w[N-1:0];
    if (v >= P_C) v = v - P_C;
    if (s == 0) v = P_C - 1;
    if (s == 1) v = '0;
    return v;
  endfunction

  task automatic push(input logic [2*N-1:0] d, input logic [1:0] m,
                      input logic [TAG_W-1:0] t, input logic [N-1:0] want,
                      input logic werr);
    txn_t x;
    x.data = d; x.mode = m; x.tag = t; x.want = want; x.werr = werr; x.cyc = 0;
    stim_q.push_back(x);
  endtask

  task automatic push_rand(input logic [1:0] m, input logic [TAG_W-1:0] t);
    logic [2*N-1:0] d;
    if (m == 2'd0) d = ($urandom_range(0, 9) == 0) ? {2*N{1'b1}} : rand_wide();
    else if (m == 2'd3) d = rand_wide();
    else d = {rand_fe(), rand_fe()};
    push(d, m, t, ref_mod(d, m), m == 2'd3);
  endtask

  task automatic clear_all();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
    ready_bad  = 0;
    stable_bad = 0;
    stall_cnt  = 0;
  endtask

  // Drives stim_q into the DUT; out_ready is low inside [lo_start, lo_end].
  task automatic drive_stream(input int budget, input int lo_start, input int lo_end,
                              input int gap_pct, input int rdy_pct);
    int   k;
    txn_t x;
    k = 0;
    while ((stim_q.size() != 0 || obs_q.size() < exp_q.size()) && k < budget) begin
      @(posedge clk);
      #1;
      if (k >= lo_start && k <= lo_end) out_ready = 1'b0;
      else if (rdy_pct >= 100) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (stim_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = stim_q[0].data;
        in_mode  = stim_q[0].mode;
        in_tag   = stim_q[0].tag;
      end else begin
        in_valid = 1'b0;
        in_data  = rand_wide();
        in_mode  = 2'($urandom);
        in_tag   = TAG_W'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        x = stim_q.pop_front();
        x.cyc = cyc;
        exp_q.push_back(x);
      end
      k++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL stream_timeout: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 2'd0; in_data = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, busy, out_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/err=%b%b%b want 000", out_valid, busy, out_err);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h tag=%h want 0", out_data, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_mul();
    clear_all();
    push(2*N'(P_C), 2'd0, 4'd1, '0, 1'b0);
    push((2*N)'(1) << 255, 2'd0, 4'd2, N'(19), 1'b0);
    push({2*N{1'b1}}, 2'd0, 4'd3, N'(360), 1'b0);
    drive_stream(100, -1, -1, 0, 100);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL mul_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].want || obs_q[i].err !== 1'b0) begin
        errors++;
        $display("FAIL mul_data[%0d]: got %h err=%b want %h err=0", i, obs_q[i].data, obs_q[i].err, exp_q[i].want);
      end
      checks++;
      if (obs_q[i].tag !== exp_q[i].tag) begin
        errors++;
        $display("FAIL mul_tag[%0d]: got %h want %h", i, obs_q[i].tag, exp_q[i].tag);
      end
      checks++;
      if (obs_q[i].cyc - exp_q[i].cyc !== 3) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d want 3", i, obs_q[i].cyc - exp_q[i].cyc);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_add_sub();
    clear_all();
    push({N'(1), P_C - N'(1)}, 2'd1, 4'd4, '0, 1'b0);
    push({P_C - N'(1), P_C - N'(1)}, 2'd1, 4'd5, P_C - N'(2), 1'b0);
    push({N'(7), N'(5)}, 2'd1, 4'd6, N'(12), 1'b0);
    push({N'(1), N'(0)}, 2'd2, 4'd7, P_C - N'(1), 1'b0);
    push({N'(5), N'(7)}, 2'd2, 4'd8, N'(2), 1'b0);
    push({N'(123), N'(123)}, 2'd2, 4'd9, '0, 1'b0);
    drive_stream(100, -1, -1, 0, 100);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL addsub_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].want || obs_q[i].tag !== exp_q[i].tag || obs_q[i].err !== 1'b0) begin
        errors++;
        $display("FAIL addsub[%0d]: got %h tag=%h err=%b want %h tag=%h err=0",
                 i, obs_q[i].data, obs_q[i].tag, obs_q[i].err, exp_q[i].want, exp_q[i].tag);
      end
      checks++;
      if (obs_q[i].cyc - exp_q[i].cyc !== 3) begin
        errors++;
        $display("FAIL addsub_latency[%0d]: got %0d want 3", i, obs_q[i].cyc - exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int i = 0; i < 6; i++) push_rand(2'd0, TAG_W'(i + 1));
    drive_stream(200, 4, 9, 0, 100);
    checks++;
    if (obs_q.size() !== 6) begin
      errors++;
      $display("FAIL bp_count: got %0d want 6", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].want || obs_q[i].tag !== exp_q[i].tag) begin
        errors++;
        $display("FAIL bp_result[%0d]: got %h tag=%h want %h tag=%h",
                 i, obs_q[i].data, obs_q[i].tag, exp_q[i].want, exp_q[i].tag);
      end
    end
    checks++;
    if (stall_cnt == 0) begin
      errors++;
      $display("FAIL bp_stall_seen: got %0d stalled cycles want >0", stall_cnt);
    end
    checks++;
    if (ready_bad !== 0) begin
      errors++;
      $display("FAIL bp_in_ready: got %0d bad cycles want 0", ready_bad);
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_bad);
    end
  endtask

  task automatic test_illegal();
    clear_all();
    push_rand(2'd0, 4'h9);
    push_rand(2'd3, 4'hA);
    push_rand(2'd1, 4'hB);
    drive_stream(100, -1, -1, 0, 100);
    checks++;
    if (obs_q.size() !== 3) begin
      errors++;
      $display("FAIL illegal_count: got %0d want 3", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].want || obs_q[i].tag !== exp_q[i].tag || obs_q[i].err !== exp_q[i].werr) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h tag=%h err=%b want %h tag=%h err=%b",
                 i, obs_q[i].data, obs_q[i].tag, obs_q[i].err, exp_q[i].want, exp_q[i].tag, exp_q[i].werr);
      end
    end
  endtask

  task automatic test_random();
    int r;
    clear_all();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      push_rand((r == 0) ? 2'd3 : 2'(r % 3), TAG_W'(i));
    end
    drive_stream(2000, -1, -1, 25, 70);
    checks++;
    if (obs_q.size() !== 40) begin
      errors++;
      $display("FAIL rand_count: got %0d want 40", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].want || obs_q[i].tag !== exp_q[i].tag || obs_q[i].err !== exp_q[i].werr) begin
        errors++;
        $display("FAIL rand[%0d]: got %h tag=%h err=%b want %h tag=%h err=%b",
                 i, obs_q[i].data, obs_q[i].tag, obs_q[i].err, exp_q[i].want, exp_q[i].tag, exp_q[i].werr);
      end
      checks++;
      if (obs_q[i].cyc - exp_q[i].cyc < 3) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d want >=3", i, obs_q[i].cyc - exp_q[i].cyc);
      end
    end
    checks++;
    if (ready_bad !== 0 || stable_bad !== 0) begin
      errors++;
      $display("FAIL rand_handshake: got ready_bad=%0d stable_bad=%0d want 0/0", ready_bad, stable_bad);
    end
  endtask

  task automatic test_reset_midstream();
    clear_all();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_data  = rand_wide();
      in_tag   = TAG_W'(i + 5);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_inflight: got valid=%b busy=%b want 1/1", out_valid, busy);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got data=%h tag=%h err=%b want 0", out_data, out_tag, out_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: got %0d outputs busy=%b want 0/0", obs_q.size(), busy);
    end
    push_rand(2'd0, 4'hC);
    drive_stream(50, -1, -1, 0, 100);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== exp_q[0].want || obs_q[0].tag !== 4'hC) begin
        errors++;
        $display("FAIL midrst_result: got %h tag=%h want %h tag=c", obs_q[0].data, obs_q[0].tag, exp_q[0].want);
      end
      checks++;
      if (obs_q[0].cyc - exp_q[0].cyc !== 3) begin
        errors++;
        $display("FAIL midrst_latency: got %0d want 3", obs_q[0].cyc - exp_q[0].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_add_sub();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
